wb_reg_bank: RTL and testbench

Parametrised Wishbone register bank: NREGS 32-bit registers behind a single pipelined Wishbone slave, with byte-lane writes, per-register read-only selection, per-register write strobes and bus error on unmapped addresses. It is the generic successor of our fixed two-register control blocks. It sits between the Wishbone interconnect and block-level control/status logic in the same clock domain.

---
 rtl/wb_reg_bank_if.sv | 27 ++
 rtl/wb_reg_bank.sv | 147 ++++++++++++++
 tb/tb_wb_reg_bank.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/wb_reg_bank_if.sv
// Pipelined Wishbone slave bundle used by wb_reg_bank.
// dat_w is master-to-slave write data; dat_r is slave-to-master read data.
interface wb_reg_bank_if #(
    parameter int unsigned ADDR_W = 4
);
    logic              cyc;
    logic              stb;
    logic [ADDR_W-1:0] adr;
    logic [3:0]        sel;
    logic              we;
    logic [31:0]       dat_w;
    logic              ack;
    logic              err;
    logic              rty;
    logic              stall;
    logic [31:0]       dat_r;

    modport master (
        output cyc, stb, adr, sel, we, dat_w,
        input  ack, err, rty, stall, dat_r
    );

    modport slave (
        input  cyc, stb, adr, sel, we, dat_w,
        output ack, err, rty, stall, dat_r
    );
endinterface

// File: rtl/wb_reg_bank.sv
// Parametrised Wishbone register bank: NREGS 32-bit registers with byte-lane
// writes, read-only status registers, per-register write strobes and bus error.
module wb_reg_bank #(
    parameter int unsigned          NREGS     = 4,
    parameter int unsigned          ADDR_W    = 4,
    parameter logic [NREGS*32-1:0]  RESET_VAL = '0,
    parameter logic [NREGS-1:0]     RO_MASK   = '0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    wb_reg_bank_if.slave        wb,
    output logic [NREGS*32-1:0] regs_o,
    input  logic [NREGS*32-1:0] regs_i,
    output logic [NREGS-1:0]    wr_strobe_o
);
    localparam int unsigned DW = 32;
    localparam int unsigned NB = DW / 8;

    logic              busy_q,   busy_d;
    logic              d0_vld_q, d0_vld_d;
    logic [ADDR_W-1:0] d0_adr_q, d0_adr_d;
    logic              d0_we_q,  d0_we_d;
    logic [NB-1:0]     d0_sel_q, d0_sel_d;
    logic [DW-1:0]     d0_dat_q, d0_dat_d;
    logic [DW-1:0]     regs_q [NREGS];
    logic [DW-1:0]     regs_d [NREGS];
    logic              ack_q,    ack_d;
    logic              err_q,    err_d;
    logic [DW-1:0]     dat_q,    dat_d;
    logic [NREGS-1:0]  strobe_q, strobe_d;

    logic              accept_c;
    logic              mapped_c;
    logic [NREGS-1:0]  hit_c;
    logic [DW-1:0]     rdata_c;

    assign accept_c = wb.cyc & wb.stb & ~busy_q;
    assign mapped_c = (32'(d0_adr_q) < NREGS);

    // Address decode and read mux; read-only slots return the live status input.
    always_comb begin
        hit_c   = '0;
        rdata_c = '0;
        for (int i = 0; i < int'(NREGS); i++) begin
            if (d0_vld_q && (d0_adr_q == ADDR_W'(i))) begin
                hit_c[i] = 1'b1;
                rdata_c  = RO_MASK[i] ? regs_i[DW*i +: DW] : regs_q[i];
            end
        end
    end

    always_comb begin
        busy_d   = busy_q;
        d0_vld_d = accept_c;
        d0_adr_d = d0_adr_q;
        d0_we_d  = d0_we_q;
        d0_sel_d = d0_sel_q;
        d0_dat_d = d0_dat_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        dat_d    = dat_q;
        strobe_d = '0;
        for (int i = 0; i < int'(NREGS); i++) begin
            regs_d[i] = regs_q[i];
        end

        // Busy spans accept through the ack/err cycle, giving a 3-cycle turnaround.
        if (ack_q || err_q) begin
            busy_d = 1'b0;
        end
        if (accept_c) begin
            busy_d   = 1'b1;
            d0_adr_d = wb.adr;
            d0_we_d  = wb.we;
            d0_sel_d = wb.sel;
            d0_dat_d = wb.dat_w;
        end

        if (d0_vld_q) begin
            ack_d = mapped_c;
            err_d = ~mapped_c;
            if (!mapped_c) begin
                dat_d = '0;
            end else if (!d0_we_q) begin
                dat_d = rdata_c;
            end
        end

        for (int i = 0; i < int'(NREGS); i++) begin
            if (hit_c[i] && d0_we_q && !RO_MASK[i]) begin
                for (int b = 0; b < int'(NB); b++) begin
                    if (d0_sel_q[b]) begin
                        regs_d[i][8*b +: 8] = d0_dat_q[8*b +: 8];
                    end
                end
                strobe_d[i] = |d0_sel_q;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_q   <= 1'b0;
            d0_vld_q <= 1'b0;
            d0_adr_q <= '0;
            d0_we_q  <= 1'b0;
            d0_sel_q <= '0;
            d0_dat_q <= '0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            dat_q    <= '0;
            strobe_q <= '0;
            for (int i = 0; i < int'(NREGS); i++) begin
                regs_q[i] <= RO_MASK[i] ? '0 : RESET_VAL[DW*i +: DW];
            end
        end else begin
            busy_q   <= busy_d;
            d0_vld_q <= d0_vld_d;
            d0_adr_q <= d0_adr_d;
            d0_we_q  <= d0_we_d;
            d0_sel_q <= d0_sel_d;
            d0_dat_q <= d0_dat_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            dat_q    <= dat_d;
            strobe_q <= strobe_d;
            for (int i = 0; i < int'(NREGS); i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    always_comb begin
        regs_o = '0;
        for (int i = 0; i < int'(NREGS); i++) begin
            regs_o[DW*i +: DW] = regs_q[i];
        end
    end

    // Stall while a request is presented, except in the ack/err cycle.
    assign wb.stall    = wb.cyc & wb.stb & ~(ack_q | err_q);
    assign wb.ack      = ack_q;
    assign wb.err      = err_q;
    assign wb.rty      = 1'b0;
    assign wb.dat_r    = dat_q;
    assign wr_strobe_o = strobe_q;
endmodule

// File: tb/tb_wb_reg_bank.sv
// Directed scoreboard bench for wb_reg_bank (NREGS=4, reg1 reset 0x123, reg3 read-only).
module tb_wb_reg_bank;
    localparam int unsigned NREGS  = 4;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned RW     = NREGS * 32;
    localparam logic [RW-1:0]    RESET_VAL = {32'h0, 32'h0, 32'h0000_0123, 32'h0};
    localparam logic [NREGS-1:0] RO_MASK   = 4'b1000;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [RW-1:0]    regs_o;
    logic [RW-1:0]    regs_i;
    logic [NREGS-1:0] wr_strobe;

    wb_reg_bank_if #(.ADDR_W(ADDR_W)) wb ();

    wb_reg_bank #(
        .NREGS    (NREGS),
        .ADDR_W   (ADDR_W),
        .RESET_VAL(RESET_VAL),
        .RO_MASK  (RO_MASK)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .wb         (wb),
        .regs_o     (regs_o),
        .regs_i     (regs_i),
        .wr_strobe_o(wr_strobe)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             err;
        logic [31:0]      dat;
        logic [NREGS-1:0] strb;
        logic [RW-1:0]    regs;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] mdl [NREGS];
    logic [31:0] last_dat;

    task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [RW-1:0] view();
        logic [RW-1:0] v;
        for (int i = 0; i < int'(NREGS); i++) v[32*i +: 32] = mdl[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < int'(NREGS); i++)
            mdl[i] = RO_MASK[i] ? 32'h0 : RESET_VAL[32*i +: 32];
        last_dat = 32'h0;
    endtask

    // Drive one transfer from a negedge; stb stays high on return so the next call is back-to-back.
    task automatic txn(input string name, input logic we, input logic [ADDR_W-1:0] adr,
                       input logic [3:0] sel, input logic [31:0] dat, input int exp_lat);
        exp_t e;
        exp_t got;
        int   n;
        bit   done;
        bit   stall_ok;
        e.err  = (32'(adr) >= NREGS);
        e.strb = '0;
        if (e.err) begin
            last_dat = 32'h0;
        end else if (we) begin
            if (!RO_MASK[adr]) begin
                for (int k = 0; k < 4; k++)
                    if (sel[k]) mdl[adr][8*k +: 8] = dat[8*k +: 8];
                if (|sel) e.strb[adr] = 1'b1;
            end
        end else begin
            last_dat = RO_MASK[adr] ? regs_i[32*adr +: 32] : mdl[adr];
        end
        e.dat  = last_dat;
        e.regs = view();
        sb.push_back(e);

        wb.cyc   = 1'b1;
        wb.stb   = 1'b1;
        wb.we    = we;
        wb.adr   = adr;
        wb.sel   = sel;
        wb.dat_w = dat;
        n        = 0;
        done     = 1'b0;
        stall_ok = 1'b1;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
            if (wb.ack || wb.err) done = 1'b1;
            else if (!wb.stall) stall_ok = 1'b0;
        end
        got = sb.pop_front();
        chk({name, ".done"},     RW'(done),      RW'(1));
        chk({name, ".latency"},  RW'(n),         RW'(exp_lat));
        chk({name, ".ack"},      RW'(wb.ack),    RW'(!got.err));
        chk({name, ".err"},      RW'(wb.err),    RW'(got.err));
        chk({name, ".dat"},      RW'(wb.dat_r),  RW'(got.dat));
        chk({name, ".strobe"},   RW'(wr_strobe), RW'(got.strb));
        chk({name, ".regs"},     regs_o,         got.regs);
        chk({name, ".stall_wait"}, RW'(stall_ok), RW'(1));
        chk({name, ".stall_ack"},  RW'(wb.stall), RW'(0));
    endtask

    task automatic idle(input string name);
        wb.cyc = 1'b0;
        wb.stb = 1'b0;
        @(negedge clk);
        chk({name, ".ack_drop"},    RW'(wb.ack),    RW'(0));
        chk({name, ".err_drop"},    RW'(wb.err),    RW'(0));
        chk({name, ".strobe_drop"}, RW'(wr_strobe), RW'(0));
    endtask

    initial begin
        bit seen;
        regs_i   = {32'hCAFE_F00D, 32'hBAD0_0002, 32'hBAD0_0001, 32'hBAD0_0000};
        wb.cyc   = 1'b0;
        wb.stb   = 1'b0;
        wb.we    = 1'b0;
        wb.adr   = '0;
        wb.sel   = '0;
        wb.dat_w = '0;
        model_reset();

        // Asynchronous reset applied mid-cycle
        #3 rst = 1'b1;
        #1;
        chk("rst.regs",   regs_o,         view());
        chk("rst.ack",    RW'(wb.ack),    RW'(0));
        chk("rst.err",    RW'(wb.err),    RW'(0));
        chk("rst.dat",    RW'(wb.dat_r),  RW'(0));
        chk("rst.strobe", RW'(wr_strobe), RW'(0));
        chk("rst.rty",    RW'(wb.rty),    RW'(0));
        chk("rst.stall",  RW'(wb.stall),  RW'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        txn("wr2_full", 1'b1, 4'd2, 4'hF, 32'hDEAD_BEEF, 2); idle("wr2_full");
        txn("rd2",      1'b0, 4'd2, 4'h0, 32'h0,         2); idle("rd2");

        txn("wr0_full", 1'b1, 4'd0, 4'hF, 32'h1122_3344, 2); idle("wr0_full");
        txn("wr0_sel5", 1'b1, 4'd0, 4'h5, 32'hAABB_CCDD, 2); idle("wr0_sel5");
        txn("wr0_sel0", 1'b1, 4'd0, 4'h0, 32'h5555_5555, 2); idle("wr0_sel0");
        txn("rd0",      1'b0, 4'd0, 4'h3, 32'h0,         2); idle("rd0");
        chk("reg0_lanes", RW'(regs_o[31:0]), RW'(32'h11BB_33DD));

        txn("rd3_ro",   1'b0, 4'd3, 4'hF, 32'h0,         2); idle("rd3_ro");
        txn("wr3_ro",   1'b1, 4'd3, 4'hF, 32'h1234_5678, 2); idle("wr3_ro");
        txn("rd1_rst",  1'b0, 4'd1, 4'hF, 32'h0,         2); idle("rd1_rst");

        txn("rd9_unmap", 1'b0, 4'd9, 4'hF, 32'h0,         2); idle("rd9_unmap");
        txn("rd2_again", 1'b0, 4'd2, 4'hF, 32'h0,         2); idle("rd2_again");
        txn("wr9_unmap", 1'b1, 4'd9, 4'hF, 32'h0BAD_0BAD, 2); idle("wr9_unmap");

        // Back-to-back writes with stb held across acks
        txn("b2b_1", 1'b1, 4'd1, 4'hF, 32'h0101_0101, 2);
        txn("b2b_2", 1'b1, 4'd2, 4'hF, 32'h0202_0202, 3);
        txn("b2b_3", 1'b1, 4'd0, 4'hF, 32'h0303_0303, 3);
        idle("b2b");

        // Reset between accept and ack drops the transfer
        wb.cyc   = 1'b1;
        wb.stb   = 1'b1;
        wb.we    = 1'b1;
        wb.adr   = 4'd2;
        wb.sel   = 4'hF;
        wb.dat_w = 32'h5555_AAAA;
        @(posedge clk);
        #2 rst = 1'b1;
        model_reset();
        #1;
        chk("midrst.ack",    RW'(wb.ack),    RW'(0));
        chk("midrst.regs",   regs_o,         view());
        chk("midrst.dat",    RW'(wb.dat_r),  RW'(0));
        @(negedge clk);
        rst    = 1'b0;
        wb.cyc = 1'b0;
        wb.stb = 1'b0;
        seen   = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (wb.ack || wb.err || (|wr_strobe)) seen = 1'b1;
        end
        chk("midrst.no_ack", RW'(seen), RW'(0));
        chk("midrst.regs_after", regs_o, view());

        txn("post_rst_rd1", 1'b0, 4'd1, 4'hF, 32'h0, 2); idle("post_rst_rd1");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
